payout_hopper: RTL and testbench

PAYOUT_HOPPER -- requirements
Module: payout_hopper

---
 rtl/payout_hopper_pkg.sv | 26 ++
 rtl/payout_hopper_if.sv | 25 ++
 rtl/payout_hopper_pay_tick.sv | 33 +++
 rtl/payout_hopper.sv | 113 +++++++++++
 tb/tb_payout_hopper.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/payout_hopper_pkg.sv
// Shared slot-machine constants: payout hopper and game control FSM
// encodings, default hopper timing and payout limits.
package payout_hopper_pkg;

  localparam int DEFAULT_TICK_DIV   = 25_000_000;  // 0.5 s per coin at 50 MHz
  localparam int DEFAULT_MAX_AMOUNT = 999;         // largest payout honoured
  localparam int AMT_W              = 10;          // credits bus width
  localparam int TOTAL_W            = 14;          // lifetime coin counter width

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_HALT     = 2'd2,
    ST_DONE     = 2'd3
  } hop_state_t;

  // Game control FSM encodings; PAY is the state that issues pay_req.
  typedef enum logic [2:0] {
    CTRL_IDLE = 3'd0,
    CTRL_BET  = 3'd1,
    CTRL_SPIN = 3'd2,
    CTRL_EVAL = 3'd3,
    CTRL_PAY  = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/payout_hopper_if.sv
// Request/status bundle between the game controller (master) and the
// payout hopper (slave).
interface payout_hopper_if;
  import payout_hopper_pkg::*;

  logic               pay_req;
  logic [AMT_W-1:0]   pay_amount;
  logic               hopper_empty;
  logic               pay_ack;
  logic               busy;
  logic               coin_pulse;
  logic [AMT_W-1:0]   coins_left;
  logic               done;
  logic [TOTAL_W-1:0] total_paid;

  modport master (
    output pay_req, pay_amount, hopper_empty,
    input  pay_ack, busy, coin_pulse, coins_left, done, total_paid
  );

  modport slave (
    input  pay_req, pay_amount, hopper_empty,
    output pay_ack, busy, coin_pulse, coins_left, done, total_paid
  );
endinterface

// File: rtl/payout_hopper_pay_tick.sv
// Coin-rate divider: counts 0..TICK_DIV-1 while enabled and flags the
// wrap cycle. clear has priority and restarts the count at zero.
module pay_tick #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int              CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Tick is the last count of the period, so the FSM acts on the wrap edge.
  assign tick = enable && (cnt == LAST);

  // Divider count: cleared on demand, frozen when not enabled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/payout_hopper.sv
// Coin payout hopper: accepts a payout request, dispenses one coin per
// divider tick, halts while the hopper is empty and reports completion.
module payout_hopper
  import payout_hopper_pkg::*;
#(
  parameter int TICK_DIV   = DEFAULT_TICK_DIV,
  parameter int MAX_AMOUNT = DEFAULT_MAX_AMOUNT
) (
  input  logic          clock,
  input  logic          reset,
  payout_hopper_if.slave bus
);

  localparam logic [AMT_W-1:0] MAX_AMT = AMT_W'(MAX_AMOUNT);

  function automatic logic [AMT_W-1:0] clamp_amount(input logic [AMT_W-1:0] amt);
    return (amt > MAX_AMT) ? MAX_AMT : amt;
  endfunction

  function automatic logic [TOTAL_W-1:0] sat_inc_total(input logic [TOTAL_W-1:0] t);
    return (t == '1) ? t : t + 1'b1;
  endfunction

  hop_state_t         state;
  logic               tick;
  logic               accept;
  logic               release_halt;
  logic               div_clear;
  logic               div_enable;
  logic [AMT_W-1:0]   amt_clamped;

  logic               pay_ack_r;
  logic               busy_r;
  logic               coin_pulse_r;
  logic [AMT_W-1:0]   coins_left_r;
  logic               done_r;
  logic [TOTAL_W-1:0] total_paid_r;

  // Divider restarts on a new payout and when the hopper refills in HALT;
  // it only advances while dispensing, which freezes it in HALT.
  assign accept       = (state == ST_IDLE) && bus.pay_req;
  assign release_halt = (state == ST_HALT) && !bus.hopper_empty;
  assign div_clear    = accept || release_halt;
  assign div_enable   = (state == ST_DISPENSE);
  assign amt_clamped  = clamp_amount(bus.pay_amount);

  pay_tick #(.TICK_DIV(TICK_DIV)) u_pay_tick (
    .clock  (clock),
    .reset  (reset),
    .clear  (div_clear),
    .enable (div_enable),
    .tick   (tick)
  );

  // Payout FSM with all outputs registered; pulses default low each cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      pay_ack_r    <= 1'b0;
      busy_r       <= 1'b0;
      coin_pulse_r <= 1'b0;
      coins_left_r <= '0;
      done_r       <= 1'b0;
      total_paid_r <= '0;
    end else begin
      pay_ack_r    <= 1'b0;
      coin_pulse_r <= 1'b0;
      done_r       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.pay_req) begin
            pay_ack_r    <= 1'b1;
            busy_r       <= 1'b1;
            coins_left_r <= amt_clamped;
            state        <= (amt_clamped == '0) ? ST_DONE : ST_DISPENSE;
          end
        end
        ST_DISPENSE: begin
          if (tick) begin
            if (bus.hopper_empty) begin
              state <= ST_HALT;
            end else begin
              coin_pulse_r <= 1'b1;
              total_paid_r <= sat_inc_total(total_paid_r);
              if (coins_left_r != '0) coins_left_r <= coins_left_r - 1'b1;
              if (coins_left_r <= AMT_W'(1)) state <= ST_DONE;
            end
          end
        end
        ST_HALT: begin
          if (!bus.hopper_empty) state <= ST_DISPENSE;
        end
        ST_DONE: begin
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          state  <= ST_IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pay_ack    = pay_ack_r;
  assign bus.busy       = busy_r;
  assign bus.coin_pulse = coin_pulse_r;
  assign bus.coins_left = coins_left_r;
  assign bus.done       = done_r;
  assign bus.total_paid = total_paid_r;

endmodule

// File: tb/tb_payout_hopper.sv
// Bench for payout_hopper with TICK_DIV=4: directed scenarios followed by
// randomized payouts, hopper stalls, stray requests and hopper_empty noise.
module tb_payout_hopper;
  import payout_hopper_pkg::*;

  localparam int TD   = 4;
  localparam int MAXA = 999;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;
  int   model_total = 0;

  always #5 clock = ~clock;

  payout_hopper_if bus ();

  payout_hopper #(.TICK_DIV(TD), .MAX_AMOUNT(MAXA)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input int ack, input int coin,
                         input int left, input int dn, input int bsy);
    chk({tag, " pay_ack"},    32'(bus.pay_ack),    32'(ack));
    chk({tag, " coin_pulse"}, 32'(bus.coin_pulse), 32'(coin));
    chk({tag, " coins_left"}, 32'(bus.coins_left), 32'(left));
    chk({tag, " done"},       32'(bus.done),       32'(dn));
    chk({tag, " busy"},       32'(bus.busy),       32'(bsy));
    chk({tag, " total_paid"}, 32'(bus.total_paid), 32'(model_total));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bus.pay_req      = 1'b0;
      bus.pay_amount   = 10'($urandom_range(0, 1023));
      bus.hopper_empty = 1'($urandom_range(0, 1));
      step();
      chk_all("idle", 0, 0, 0, 0, 0);
    end
  endtask

  // Expected timeline, in edges after the accepting edge (edge 0):
  // a coin every TD edges; a stall at tick h holds for L edges of
  // hopper_empty=1, then the coin comes TD edges after release.
  // stray: 0 none, 1 random, 2 every cycle while the payout is in flight.
  task automatic run_payout(input int amt, input int h, input int L, input int stray);
    int n;
    int t;
    int halt_e;
    int rel_e;
    int d_e;
    int ci;
    int issued;
    int coin_e[$];
    string tag;
    n = (amt > MAXA) ? MAXA : amt;
    t = 0;
    halt_e = -1;
    rel_e = -1;
    for (int k = 1; k <= n; k++) begin
      if (k == h) begin
        t += TD;
        halt_e = t;
        t += L;
        rel_e = t;
      end
      t += TD;
      coin_e.push_back(t);
    end
    d_e = (n == 0) ? 1 : coin_e[coin_e.size()-1] + 1;
    ci = 0;
    issued = 0;
    for (int e = 0; e <= d_e; e++) begin
      if (e == 0) begin
        bus.pay_req    = 1'b1;
        bus.pay_amount = 10'(amt);
      end else begin
        bus.pay_req    = (stray == 2) ? 1'b1 :
                         (stray == 1) ? ($urandom_range(0, 2) == 0) : 1'b0;
        bus.pay_amount = 10'($urandom_range(0, 1023));
      end
      if (halt_e >= 0 && e >= halt_e && e < rel_e)      bus.hopper_empty = 1'b1;
      else if (e == rel_e)                              bus.hopper_empty = 1'b0;
      else if (ci < coin_e.size() && coin_e[ci] == e)   bus.hopper_empty = 1'b0;
      else                                              bus.hopper_empty = 1'($urandom_range(0, 1));
      step();
      tag = $sformatf("amt=%0d h=%0d L=%0d e=%0d", amt, h, L, e);
      if (ci < coin_e.size() && coin_e[ci] == e) begin
        ci++;
        issued++;
        if (model_total < 16383) model_total++;
        chk_all(tag, 0, 1, n - issued, 0, 1);
      end else begin
        chk_all(tag, (e == 0) ? 1 : 0, 0, n - issued, (e == d_e) ? 1 : 0, (e < d_e) ? 1 : 0);
      end
    end
    bus.pay_req = 1'b0;
  endtask

  initial begin
    bus.pay_req      = 1'b0;
    bus.pay_amount   = '0;
    bus.hopper_empty = 1'b0;

    // Asynchronous reset at start, checked before any clock edge.
    #2 reset = 1'b1;
    #1;
    chk_all("reset_async", 0, 0, 0, 0, 0);
    step();
    step();
    reset = 1'b0;
    chk_all("reset_release", 0, 0, 0, 0, 0);
    idle_cycles(2);

    // Three coins, clean hopper.
    run_payout(3, 0, 0, 0);
    idle_cycles(1);
    // Zero payout: ack then done, busy for exactly one cycle.
    run_payout(0, 0, 0, 0);
    idle_cycles(1);
    // Two coins, hopper empty at second tick for 10 cycles.
    run_payout(2, 2, 10, 0);
    // Requests during DISPENSE and DONE are ignored.
    run_payout(3, 0, 0, 2);
    run_payout(0, 0, 0, 2);
    idle_cycles(1);

    // Reset mid-payout with coins_left=5: everything cleared, no done.
    bus.pay_req    = 1'b1;
    bus.pay_amount = 10'd5;
    bus.hopper_empty = 1'b0;
    step();
    bus.pay_req = 1'b0;
    chk_all("pay5_accept", 1, 0, 5, 0, 1);
    step();
    chk_all("pay5_hold", 0, 0, 5, 0, 1);
    #3 reset = 1'b1;
    #1;
    model_total = 0;
    chk_all("midpay_reset_async", 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_all("after_reset_no_done", 0, 0, 0, 0, 0);
    end
    run_payout(2, 0, 0, 1);
    idle_cycles(1);

    // Oversized request saturates at MAX_AMOUNT; abandoned by reset.
    bus.pay_req    = 1'b1;
    bus.pay_amount = 10'd1023;
    step();
    bus.pay_req = 1'b0;
    chk_all("clamp_1023", 1, 0, MAXA, 0, 1);
    step();
    #2 reset = 1'b1;
    #1;
    model_total = 0;
    chk_all("clamp_reset", 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;
    idle_cycles(2);

    // Randomized payouts with stalls, noise and stray requests.
    for (int r = 0; r < 16; r++) begin
      int amt;
      int h;
      int L;
      amt = $urandom_range(0, 6);
      h   = (amt > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(1, amt) : 0;
      L   = $urandom_range(1, 12);
      run_payout(amt, h, L, 1);
      idle_cycles($urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
